dsram_rmw_ctrl: RTL and testbench

Initiator-side controller for the single-port 256-bit data SRAM. The SRAM has no byte enables, so this block turns 32-bit word reads, byte-enabled word writes and full-line fills into SRAM read / read-modify-write / write sequences. It sits between the cache pipeline request port and the data array. It allows one request outstanding at a time.

---
 rtl/dsram_rmw_ctrl.sv | 101 ++++++++++
 tb/tb_dsram_rmw_ctrl.sv | 363 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dsram_rmw_ctrl.sv
// Request-side controller for a single-port 256-bit data SRAM without byte enables.
// Word reads, byte-enabled word writes (read-modify-write) and full-line fills, one at a time.
module dsram_rmw_ctrl #(
  parameter int ADDR_WIDTH = 13
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_fill,
  input  logic                  req_write,
  input  logic [ADDR_WIDTH-1:0] req_a,
  input  logic [2:0]            req_offset,
  input  logic [3:0]            req_be,
  input  logic [31:0]           req_wd,
  input  logic [255:0]          req_line,
  output logic                  rsp_valid,
  output logic [31:0]           rsp_rd,
  output logic [ADDR_WIDTH-1:0] ram_a,
  output logic [255:0]          ram_wd,
  output logic                  ram_read,
  output logic                  ram_write,
  input  logic [255:0]          ram_rd
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD,
    S_MRG,
    S_WR,
    S_RSP
  } state_t;

  state_t        state, state_nxt;
  logic          accept;
  logic          op_write;
  logic [2:0]    op_offset;
  logic [3:0]    op_be;
  logic [31:0]   op_wd;
  logic [255:0]  merged;

  // Strobes come straight from the state register so an async reset kills them at once.
  assign req_ready = (state == S_IDLE);
  assign ram_read  = (state == S_RD);
  assign ram_write = (state == S_WR);
  assign rsp_valid = (state == S_RSP);
  assign accept    = req_valid & req_ready;

  // NOTE: every variable assigned in an always_comb gets a default first, so no path infers a latch.
  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:  if (accept) state_nxt = req_fill ? S_WR : S_RD;
      S_RD:    state_nxt = S_MRG;
      S_MRG:   state_nxt = op_write ? S_WR : S_RSP;
      S_WR:    state_nxt = S_RSP;
      S_RSP:   state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Replace only the enabled bytes of the addressed word; the rest of the line passes through.
  always_comb begin
    merged = ram_rd;
    for (int i = 0; i < 4; i++) begin
      if (op_be[i]) merged[32*int'(op_offset) + 8*i +: 8] = op_wd[8*i +: 8];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_write  <= 1'b0;
      op_offset <= '0;
      op_be     <= '0;
      op_wd     <= '0;
      ram_a     <= '0;
      ram_wd    <= '0;
      rsp_rd    <= '0;
    end else begin
      if (accept) begin
        op_write  <= req_write & ~req_fill;
        op_offset <= req_offset;
        op_be     <= req_be;
        op_wd     <= req_wd;
        ram_a     <= req_a;
        if (req_fill) ram_wd <= req_line;
      end
      if (state == S_MRG) begin
        if (op_write) ram_wd <= merged;
        else          rsp_rd <= ram_rd[32*int'(op_offset) +: 32];
      end
    end
  end

endmodule

// File: tb/tb_dsram_rmw_ctrl.sv
// Self-checking bench for dsram_rmw_ctrl: SRAM behavioural model plus a byte-array reference
// of line contents; directed scenarios followed by randomized read/write/fill traffic.
module tb_dsram_rmw_ctrl;
  localparam int AW    = 6;
  localparam int LINES = 1 << AW;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic          req_fill = 1'b0;
  logic          req_write = 1'b0;
  logic [AW-1:0] req_a = '0;
  logic [2:0]    req_offset = '0;
  logic [3:0]    req_be = '0;
  logic [31:0]   req_wd = '0;
  logic [255:0]  req_line = '0;
  logic          rsp_valid;
  logic [31:0]   rsp_rd;
  logic [AW-1:0] ram_a;
  logic [255:0]  ram_wd;
  logic          ram_read;
  logic          ram_write;
  logic [255:0]  ram_rd = '0;

  int n_cmp = 0;
  int n_bad = 0;

  logic [255:0] sram [LINES];
  logic [7:0]   ref_b [LINES][32];

  dsram_rmw_ctrl #(.ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_fill(req_fill), .req_write(req_write),
    .req_a(req_a), .req_offset(req_offset), .req_be(req_be),
    .req_wd(req_wd), .req_line(req_line),
    .rsp_valid(rsp_valid), .rsp_rd(rsp_rd),
    .ram_a(ram_a), .ram_wd(ram_wd),
    .ram_read(ram_read), .ram_write(ram_write), .ram_rd(ram_rd)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ram_write) sram[ram_a] <= ram_wd;
    if (ram_read)  ram_rd <= sram[ram_a];
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] model_word(input int a, input int off);
    return {ref_b[a][off*4+3], ref_b[a][off*4+2], ref_b[a][off*4+1], ref_b[a][off*4]};
  endfunction

  function automatic logic [255:0] model_line(input int a);
    logic [255:0] l;
    for (int b = 0; b < 32; b++) l[8*b +: 8] = ref_b[a][b];
    return l;
  endfunction

  function automatic logic [255:0] rand_line();
    logic [255:0] l;
    for (int k = 0; k < 8; k++) l[32*k +: 32] = $urandom;
    return l;
  endfunction

  // kind: 0 = read, 1 = write, 2 = fill. Drives one request, checks strobe timing,
  // address, write data and read data against the reference, and returns the read word.
  task automatic run_op(input int kind, input int a, input int off, input logic [3:0] be,
                        input logic [31:0] wd, input logic [255:0] line, output logic [31:0] got);
    logic [255:0] exp_line;
    logic [31:0]  exp_word;
    int rd_cyc, wr_cyc, rsp_cyc, n_rd, n_wr, n_rsp, waited;
    int e_rd, e_wr, e_rsp;
    exp_word = model_word(a, off);
    if (kind == 2) for (int b = 0; b < 32; b++) ref_b[a][b] = line[8*b +: 8];
    if (kind == 1) for (int i = 0; i < 4; i++) if (be[i]) ref_b[a][off*4+i] = wd[8*i +: 8];
    exp_line = model_line(a);
    e_rd  = (kind == 2) ? -1 : 1;
    e_wr  = (kind == 0) ? -1 : ((kind == 1) ? 3 : 1);
    e_rsp = (kind == 0) ? 3 : ((kind == 1) ? 4 : 2);
    got = 'x;

    @(negedge clk);
    req_valid  = 1'b1;
    req_fill   = (kind == 2);
    req_write  = (kind == 1);
    req_a      = AW'(a);
    req_offset = 3'(off);
    req_be     = be;
    req_wd     = wd;
    req_line   = line;
    waited = 0;
    while (req_ready !== 1'b1 && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    n_cmp++;
    if (waited >= 20) begin
      n_bad++;
      $display("FAIL accept_timeout: req_ready=%b after %0d cycles, required 1", req_ready, waited);
      req_valid = 1'b0;
      return;
    end
    @(negedge clk);
    req_valid  = 1'b0;
    req_fill   = $urandom_range(0, 1);
    req_write  = $urandom_range(0, 1);
    req_a      = AW'($urandom);
    req_offset = 3'($urandom);
    req_be     = 4'($urandom);
    req_wd     = $urandom;
    req_line   = rand_line();

    rd_cyc = -1; wr_cyc = -1; rsp_cyc = -1; n_rd = 0; n_wr = 0; n_rsp = 0;
    for (int c = 1; c <= 7; c++) begin
      if (c > 1) @(negedge clk);
      if (ram_read === 1'b1) begin
        n_rd++;
        if (rd_cyc < 0) rd_cyc = c;
        n_cmp++;
        if (ram_a !== AW'(a)) begin
          n_bad++;
          $display("FAIL rd_addr: ram_a=%0d required %0d", ram_a, a);
        end
      end
      if (ram_write === 1'b1) begin
        n_wr++;
        if (wr_cyc < 0) wr_cyc = c;
        n_cmp++;
        if (ram_a !== AW'(a) || ram_wd !== exp_line) begin
          n_bad++;
          $display("FAIL wr_data: ram_a=%0d ram_wd=%h required a=%0d wd=%h", ram_a, ram_wd, a, exp_line);
        end
      end
      if (rsp_valid === 1'b1) begin
        n_rsp++;
        if (rsp_cyc < 0) rsp_cyc = c;
        got = rsp_rd;
        if (kind == 0) begin
          n_cmp++;
          if (rsp_rd !== exp_word) begin
            n_bad++;
            $display("FAIL rd_word: line %0d off %0d rsp_rd=%h required %h", a, off, rsp_rd, exp_word);
          end
        end
      end
    end
    n_cmp++;
    if (rd_cyc != e_rd || wr_cyc != e_wr || rsp_cyc != e_rsp ||
        n_rd != (e_rd > 0 ? 1 : 0) || n_wr != (e_wr > 0 ? 1 : 0) || n_rsp != 1) begin
      n_bad++;
      $display("FAIL timing kind=%0d: rd@%0d x%0d wr@%0d x%0d rsp@%0d x%0d required rd@%0d wr@%0d rsp@%0d (once each)",
               kind, rd_cyc, n_rd, wr_cyc, n_wr, rsp_cyc, n_rsp, e_rd, e_wr, e_rsp);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req_valid = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      n_cmp++;
      if (ram_read !== 1'b0 || ram_write !== 1'b0 || rsp_valid !== 1'b0) begin
        n_bad++;
        $display("FAIL reset_strobes: rd=%b wr=%b rsp=%b required 000", ram_read, ram_write, rsp_valid);
      end
    end
    rst_n = 1'b1;
    req_valid = 1'b0;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      n_cmp++;
      if ({req_ready, ram_read, ram_write, rsp_valid} !== 4'b1000 || rsp_rd !== 32'h0 ||
          ram_a !== '0 || ram_wd !== '0) begin
        n_bad++;
        $display("FAIL reset_state: rdy/rd/wr/rsp=%b rsp_rd=%h ram_a=%0d ram_wd=%h required 1000/0/0/0",
                 {req_ready, ram_read, ram_write, rsp_valid}, rsp_rd, ram_a, ram_wd);
      end
    end
  endtask

  task automatic test_fill_read();
    logic [255:0] l;
    logic [31:0]  got;
    for (int k = 0; k < 8; k++) l[32*k +: 32] = 32'h5000_0000 + 32'(k);
    run_op(2, 5, 0, 4'h0, 32'h0, l, got);
    run_op(0, 5, 3, 4'h0, 32'h0, '0, got);
    n_cmp++;
    if (got !== 32'h5000_0003) begin
      n_bad++;
      $display("FAIL fill_read: rsp_rd=%h required 50000003", got);
    end
  endtask

  task automatic test_partial_write();
    logic [31:0] got;
    logic [31:0] want [3];
    int offs [3];
    want = '{32'h50BB00DD, 32'h5000_0005, 32'h5000_0007};
    offs = '{6, 5, 7};
    run_op(1, 5, 6, 4'b0101, 32'hAABBCCDD, '0, got);
    for (int i = 0; i < 3; i++) begin
      run_op(0, 5, offs[i], 4'h0, 32'h0, '0, got);
      n_cmp++;
      if (got !== want[i]) begin
        n_bad++;
        $display("FAIL partial_write off %0d: rsp_rd=%h required %h", offs[i], got, want[i]);
      end
    end
  endtask

  task automatic test_degenerate_be();
    logic [31:0] got;
    run_op(1, 5, 2, 4'h0, 32'hFFFF_FFFF, '0, got);
    run_op(0, 5, 2, 4'h0, 32'h0, '0, got);
    n_cmp++;
    if (got !== 32'h5000_0002) begin
      n_bad++;
      $display("FAIL be0_unchanged: rsp_rd=%h required 50000002", got);
    end
    run_op(1, 5, 0, 4'hF, 32'hDEADBEEF, '0, got);
    run_op(0, 5, 0, 4'h0, 32'h0, '0, got);
    n_cmp++;
    if (got !== 32'hDEADBEEF) begin
      n_bad++;
      $display("FAIL beF_word0: rsp_rd=%h required deadbeef", got);
    end
    run_op(0, 5, 1, 4'h0, 32'h0, '0, got);
    n_cmp++;
    if (got !== 32'h5000_0001) begin
      n_bad++;
      $display("FAIL beF_word1: rsp_rd=%h required 50000001", got);
    end
  endtask

  task automatic test_back_to_back();
    int offs [3];
    int acc_cyc [3];
    logic [31:0] expq [$];
    int acc, n_rsp;
    logic rdy_low_ok;
    offs = '{1, 4, 6};
    for (int i = 0; i < 3; i++) expq.push_back(model_word(5, offs[i]));
    acc = 0; n_rsp = 0; rdy_low_ok = 1'b1;
    acc_cyc = '{-1, -1, -1};
    @(negedge clk);
    for (int c = 0; c < 14; c++) begin
      req_valid  = (acc < 3);
      req_fill   = 1'b0;
      req_write  = 1'b0;
      req_a      = AW'(5);
      req_offset = 3'(offs[(acc < 3) ? acc : 2]);
      if (c >= 1 && c <= 3 && req_ready !== 1'b0) rdy_low_ok = 1'b0;
      if (rsp_valid === 1'b1) begin
        n_rsp++;
        n_cmp++;
        if (expq.size() == 0 || rsp_rd !== expq[0]) begin
          n_bad++;
          $display("FAIL b2b_data: rsp_rd=%h at cycle %0d required %h", rsp_rd, c,
                   expq.size() ? expq[0] : 32'h0);
        end
        if (expq.size() != 0) void'(expq.pop_front());
      end
      if (req_ready === 1'b1 && req_valid && acc < 3) begin
        acc_cyc[acc] = c;
        acc++;
      end
      @(negedge clk);
    end
    req_valid = 1'b0;
    n_cmp++;
    if (acc_cyc[0] != 0 || acc_cyc[1] != 4 || acc_cyc[2] != 8 || n_rsp != 3 || !rdy_low_ok) begin
      n_bad++;
      $display("FAIL b2b_flow: accepts at %0d,%0d,%0d rsp=%0d ready_low_1to3=%b required 0,4,8 rsp=3 1",
               acc_cyc[0], acc_cyc[1], acc_cyc[2], n_rsp, rdy_low_ok);
    end
  endtask

  task automatic test_reset_mid_write();
    logic [31:0] got;
    logic [255:0] l;
    int waited;
    logic bad_rsp;
    @(negedge clk);
    req_valid = 1'b1; req_fill = 1'b0; req_write = 1'b1;
    req_a = AW'(7); req_offset = 3'd2; req_be = 4'hF; req_wd = 32'h1234_5678;
    waited = 0;
    while (req_ready !== 1'b1 && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    n_cmp++;
    if (ram_write !== 1'b1) begin
      n_bad++;
      $display("FAIL midwr_in_wr: ram_write=%b in cycle 3 required 1", ram_write);
    end
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (ram_write !== 1'b0 || req_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL midwr_drop: ram_write=%b req_ready=%b after reset required 0 1", ram_write, req_ready);
    end
    bad_rsp = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (rsp_valid !== 1'b0 || ram_write !== 1'b0) bad_rsp = 1'b1;
    end
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (rsp_valid !== 1'b0) bad_rsp = 1'b1;
    end
    n_cmp++;
    if (bad_rsp || req_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL midwr_abandon: spurious rsp/strobe=%b req_ready=%b required 0 1", bad_rsp, req_ready);
    end
    l = rand_line();
    run_op(2, 7, 0, 4'h0, 32'h0, l, got);
    run_op(0, 7, 2, 4'h0, 32'h0, '0, got);
    n_cmp++;
    if (got !== l[95:64]) begin
      n_bad++;
      $display("FAIL midwr_recover: rsp_rd=%h required %h", got, l[95:64]);
    end
  endtask

  task automatic test_random();
    logic [31:0] got;
    for (int n = 0; n < 60; n++) begin
      run_op($urandom_range(0, 2), $urandom_range(0, LINES - 1), $urandom_range(0, 7),
             4'($urandom), $urandom, rand_line(), got);
    end
  endtask

  initial begin
    for (int a = 0; a < LINES; a++) begin
      sram[a] = rand_line();
      for (int b = 0; b < 32; b++) ref_b[a][b] = sram[a][8*b +: 8];
    end
    test_reset();
    test_fill_read();
    test_partial_write();
    test_degenerate_be();
    test_back_to_back();
    test_reset_mid_write();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
